fetch_stage: RTL and testbench

- Instruction fetch stage plus IF/ID pipeline register for the pinca-puca MIPS datapath.
- Owns the PC and runs a request/acknowledge handshake with instruction memory.
- Captures returned words and presents pre-split fields (op, fn, rs, rt, rd, imm) with a valid flag to the control decoder and register file in the decode stage.
- Handles decode-stage stall, flush and branch/jump redirect, with a one-entry holding buffer so no fetched word is lost under stall.

---
 rtl/fetch_stage.sv | 161 ++++++++++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and one-entry stall buffer
//
// Owns the PC, handshakes with instruction memory (imem_req/imem_ack), and
// presents the fetched word plus pre-split fields to the decode stage.
// Optional macro FETCH_ALIGN_CHECK_EN adds a sticky pc_misalign output.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   stall, flush          decode-stage hold / squash of the IF/ID entry
//   redirect, redirect_pc branch/jump target load (highest priority)
//   imem_req, imem_addr   fetch request and address (address is the PC)
//   imem_ack, imem_data   returned word, valid for imem_addr this cycle
//   valid, instr          IF/ID entry
//   op, rs, rt, rd, fn, imm   slices of instr
//   pc_out, pc_plus4      address of the IF/ID word and that address + 4
//   pc_misalign           (FETCH_ALIGN_CHECK_EN only) sticky unaligned-redirect flag
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        valid,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  fn,
    output logic [15:0] imm,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        pc_misalign
`endif
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HELD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= PC_RESET;
            buf_instr_q <= 32'h0;
            buf_pc_q    <= 32'h0;
            valid_q     <= 1'b0;
            instr_q     <= 32'h0;
            pc_out_q    <= 32'h0;
            pc_plus4_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            pc_plus4_q  <= pc_plus4_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        pc_plus4_d  = pc_plus4_q;

        if (redirect) begin
            // Any word acked this cycle belongs to the wrong path; dropping
            // back to S_FETCH also abandons a buffered word.
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
            valid_d = 1'b0;
            state_d = S_FETCH;
        end else begin
            if (state_q == S_FETCH) begin
                if (imem_ack) begin
                    pc_d = pc_q + 32'd4;
                    if (stall) begin
                        buf_instr_d = imem_data;
                        buf_pc_d    = pc_q;
                        state_d     = S_HELD;
                    end else begin
                        instr_d    = imem_data;
                        pc_out_d   = pc_q;
                        pc_plus4_d = pc_q + 32'd4;
                        valid_d    = 1'b1;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end else begin
                // A flush only kills the IF/ID entry; the buffered word waits
                // for a cycle that is neither stalled nor flushed.
                if (!stall && !flush) begin
                    instr_d    = buf_instr_q;
                    pc_out_d   = buf_pc_q;
                    pc_plus4_d = buf_pc_q + 32'd4;
                    valid_d    = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            if (flush) begin
                valid_d = 1'b0;
            end
        end
    end

    // Gated by reset so no request is issued while reset is held.
    assign imem_req  = (state_q == S_FETCH) && !reset;
    assign imem_addr = pc_q;

    assign valid    = valid_q;
    assign instr    = instr_q;
    assign op       = instr_q[31:26];
    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign rd       = instr_q[15:11];
    assign fn       = instr_q[5:0];
    assign imm      = instr_q[15:0];
    assign pc_out   = pc_out_q;
    assign pc_plus4 = pc_plus4_q;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign pc_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a queue-based reference model
module tb_fetch_stage;

    localparam logic [31:0] PC_RST = 32'h0000_0040;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall, flush, redirect, imem_ack;
    logic [31:0] redirect_pc, imem_data;
    logic        imem_req, valid;
    logic [31:0] imem_addr, instr, pc_out, pc_plus4;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        pc_misalign;
`endif

    int tests = 0;
    int fails = 0;

    fetch_stage #(.PC_RESET(PC_RST)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .valid(valid), .instr(instr), .op(op), .rs(rs), .rt(rt), .rd(rd),
        .fn(fn), .imm(imm), .pc_out(pc_out), .pc_plus4(pc_plus4)
`ifdef FETCH_ALIGN_CHECK_EN
        , .pc_misalign(pc_misalign)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: PC, a queue standing in for the holding buffer,
    // and the IF/ID record. "Waiting on memory" simply means the queue is empty.
    logic [31:0] m_pc;
    logic [63:0] m_pending[$];
    logic        m_valid;
    logic [31:0] m_instr, m_pcout;
    logic        m_loaded;
    logic        m_mis;

    function automatic logic [31:0] exp_pp4();
        return m_loaded ? m_pcout + 32'd4 : 32'd0;
    endfunction

    task automatic model_reset();
        m_pc = PC_RST;
        m_pending.delete();
        m_valid = 1'b0;
        m_instr = 32'd0;
        m_pcout = 32'd0;
        m_loaded = 1'b0;
        m_mis = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic f, input logic r,
                              input logic [31:0] rp, input logic a, input logic [31:0] d);
        logic [63:0] e;
        if (r) begin
            if (rp % 4 != 0) m_mis = 1'b1;
            m_pc = rp - (rp % 4);
            m_valid = 1'b0;
            m_pending.delete();
        end else begin
            if (m_pending.size() == 0) begin
                if (a) begin
                    if (s) m_pending.push_back({m_pc, d});
                    else begin
                        m_instr = d; m_pcout = m_pc; m_valid = 1'b1; m_loaded = 1'b1;
                    end
                    m_pc = m_pc + 32'd4;
                end else if (!s) m_valid = 1'b0;
            end else if (!s && !f) begin
                e = m_pending.pop_front();
                m_instr = e[31:0]; m_pcout = e[63:32]; m_valid = 1'b1; m_loaded = 1'b1;
            end
            if (f) m_valid = 1'b0;
        end
    endtask

    // Drives one cycle of inputs, advances one edge, updates the model,
    // and returns 1 time unit after the edge.
    task automatic step(input logic s, input logic f, input logic r,
                        input logic [31:0] rp, input logic a, input logic [31:0] d);
        stall = s; flush = f; redirect = r; redirect_pc = rp; imem_ack = a; imem_data = d;
        @(posedge clock);
        model_edge(s, f, r, rp, a, d);
        #1;
        stall = 0; flush = 0; redirect = 0; imem_ack = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall = 0; flush = 0; redirect = 0; redirect_pc = 0; imem_ack = 0; imem_data = 0;
        #13;
        model_reset();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        tests++; if ({valid, instr, pc_out, pc_plus4} !== 97'd0) begin fails++;
            $display("FAIL reset_ifid got v=%b i=%h p=%h p4=%h exp all 0", valid, instr, pc_out, pc_plus4); end
        tests++; if ({op, rs, rt, rd, fn, imm} !== 43'd0) begin fails++; $display("FAIL reset_fields got=%h exp=0", {op, rs, rt, rd, fn, imm}); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== PC_RST) begin fails++;
            $display("FAIL reset_release got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, PC_RST); end
        @(posedge clock); #1;
    endtask

    task automatic test_first_fetch();
        tests++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL ff_addr0 got=%h exp=00000040", imem_addr); end
        step(0, 0, 0, 0, 1, 32'h8C22_0004);
        tests++; if (imem_addr !== 32'h44) begin fails++; $display("FAIL ff_addr1 got=%h exp=00000044", imem_addr); end
        tests++; if (valid !== 1'b1 || op !== 6'b100011 || rt !== 5'd2 || imm !== 16'd4) begin fails++;
            $display("FAIL ff_fields got v=%b op=%b rt=%0d imm=%0d exp v=1 op=100011 rt=2 imm=4", valid, op, rt, imm); end
        tests++; if (pc_out !== 32'h40 || pc_plus4 !== 32'h44) begin fails++;
            $display("FAIL ff_pc got pc=%h p4=%h exp 00000040/00000044", pc_out, pc_plus4); end
        step(0, 0, 0, 0, 1, 32'hAC22_0008);
        tests++; if (instr !== 32'hAC22_0008 || pc_out !== 32'h44 || imem_addr !== 32'h48) begin fails++;
            $display("FAIL ff_second got i=%h pc=%h a=%h exp AC220008/00000044/00000048", instr, pc_out, imem_addr); end
    endtask

    task automatic test_ack_wait();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 32'hDEAD_BEEF);
            tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h48 || valid !== 1'b0) begin fails++;
                $display("FAIL ack_wait[%0d] got req=%b a=%h v=%b exp 1/00000048/0", i, imem_req, imem_addr, valid); end
        end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 0, 1, 32'h0043_1020);
        tests++; if (imem_req !== 1'b0 || instr !== 32'hAC22_0008 || imem_addr !== 32'h4C) begin fails++;
            $display("FAIL stall_hold got req=%b i=%h a=%h exp 0/AC220008/0000004C", imem_req, instr, imem_addr); end
        step(1, 0, 0, 0, 1, 32'h1111_1111);
        tests++; if (imem_req !== 1'b0 || instr !== 32'hAC22_0008) begin fails++;
            $display("FAIL stall_hold2 got req=%b i=%h exp 0/AC220008", imem_req, instr); end
        step(0, 0, 0, 0, 0, 32'h0);
        tests++; if (valid !== 1'b1 || instr !== 32'h0043_1020 || fn !== 6'b100000 || rd !== 5'd2 || pc_out !== 32'h48) begin fails++;
            $display("FAIL stall_release got v=%b i=%h fn=%b rd=%0d pc=%h exp 1/00431020/100000/2/00000048", valid, instr, fn, rd, pc_out); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4C) begin fails++;
            $display("FAIL stall_next got req=%b a=%h exp 1/0000004C", imem_req, imem_addr); end
    endtask

    task automatic test_redirect();
        step(1, 0, 1, 32'h0000_0100, 1, 32'h2222_2222);
        tests++; if (valid !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin fails++;
            $display("FAIL redir got v=%b a=%h req=%b exp 0/00000100/1", valid, imem_addr, imem_req); end
        // Fill the buffer, then redirect while held: the buffered word must never appear.
        step(1, 0, 0, 0, 1, 32'h3333_3333);
        step(1, 0, 1, 32'h0000_0200, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0);
            tests++; if (valid !== 1'b0 || imem_addr !== 32'h200) begin fails++;
                $display("FAIL redir_drop[%0d] got v=%b a=%h exp 0/00000200", i, valid, imem_addr); end
        end
    endtask

    task automatic test_flush();
        step(0, 0, 0, 0, 1, 32'h4444_4444);
        step(1, 0, 0, 0, 1, 32'h5555_5555);
        step(1, 1, 0, 0, 0, 0);
        tests++; if (valid !== 1'b0 || imem_req !== 1'b0) begin fails++;
            $display("FAIL flush got v=%b req=%b exp 0/0", valid, imem_req); end
        step(0, 0, 0, 0, 0, 0);
        tests++; if (valid !== 1'b1 || instr !== 32'h5555_5555 || pc_out !== 32'h204) begin fails++;
            $display("FAIL flush_drain got v=%b i=%h pc=%h exp 1/55555555/00000204", valid, instr, pc_out); end
    endtask

    task automatic test_wrap();
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0123_4567);
        tests++; if (pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 || imem_addr !== 32'h0) begin fails++;
            $display("FAIL wrap got pc=%h p4=%h a=%h exp FFFFFFFC/00000000/00000000", pc_out, pc_plus4, imem_addr); end
    endtask

    task automatic test_misalign();
        step(0, 0, 1, 32'h0000_0102, 0, 0);
        tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL misalign_addr got=%h exp=00000100", imem_addr); end
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            tests++; if (pc_misalign !== 1'b1) begin fails++; $display("FAIL misalign_flag[%0d] got=%b exp=1", i, pc_misalign); end
            step(0, 0, 1, 32'h0000_0300, 1, 0);
        end
`endif
    endtask

    task automatic test_random();
        logic s, f, r, a;
        logic [31:0] rp, d;
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 99) < 35);
            f = ($urandom_range(0, 99) < 10);
            r = ($urandom_range(0, 99) < 6);
            a = ($urandom_range(0, 99) < 60);
            rp = $urandom;
            d = $urandom;
            step(s, f, r, rp, a, d);
            tests++; if (valid !== m_valid || instr !== m_instr || pc_out !== m_pcout || pc_plus4 !== exp_pp4()) begin fails++;
                $display("FAIL rand_ifid[%0d] got v=%b i=%h pc=%h p4=%h exp v=%b i=%h pc=%h p4=%h",
                         i, valid, instr, pc_out, pc_plus4, m_valid, m_instr, m_pcout, exp_pp4()); end
            tests++; if (imem_req !== (m_pending.size() == 0) || imem_addr !== m_pc) begin fails++;
                $display("FAIL rand_imem[%0d] got req=%b a=%h exp req=%b a=%h", i, imem_req, imem_addr, m_pending.size() == 0, m_pc); end
            tests++; if ({op, rs, rt, rd, fn, imm} !== {m_instr[31:26], m_instr[25:21], m_instr[20:16], m_instr[15:11], m_instr[5:0], m_instr[15:0]}) begin fails++;
                $display("FAIL rand_fields[%0d] got op=%h rs=%h rt=%h rd=%h fn=%h imm=%h for instr=%h", i, op, rs, rt, rd, fn, imm, m_instr); end
`ifdef FETCH_ALIGN_CHECK_EN
            tests++; if (pc_misalign !== m_mis) begin fails++; $display("FAIL rand_mis[%0d] got=%b exp=%b", i, pc_misalign, m_mis); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_ack_wait();
        test_stall();
        test_redirect();
        test_flush();
        test_wrap();
        test_misalign();
        test_random();
        // Async reset asserted mid-cycle in the middle of random traffic.
        step(0, 0, 0, 0, 0, 0);
        #2;
        test_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
